photocell_emulator: RTL
=======================

PHOTOCELL_EMULATOR -- requirements
Module: photocell_emulator

Interface
REQ-001 Parameter BREAK_CYC, default 3, cycles sensor_out is held low per event; legal range 1..255.
REQ-002 Parameter GAP_CYC, default 2, minimum cycles sensor_out is held high between events; legal range 1..255.
REQ-003 Parameter PEND_W, default 2, width of the pending-event counter; maximum pending count is 2^PEND_W-1.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 evt_req  input  1  request to emit one beam-break event.
REQ-007 evt_ready  output  1  high when a request can be accepted; combinational, equal to (pending != max).
REQ-008 sensor_out  output  1  emulated photocell line; 1 = beam clear, 0 = beam broken; registered.
REQ-009 done_pulse  output  1  one-cycle pulse marking the end of an event's break phase; registered.
REQ-010 pending  output  PEND_W  events accepted but not yet started.
REQ-011 busy  output  1  high in BREAK or GAP state.
REQ-012 overflow  output  1  sticky flag; request dropped while evt_ready=0.

Function
REQ-013 Accept occurs in any cycle with evt_req=1 and evt_ready=1; each accept adds one event.
REQ-014 FSM states: IDLE (sensor_out=1), BREAK (sensor_out=0), GAP (sensor_out=1).
REQ-015 IDLE -> BREAK when pending>0 or an accept occurs that cycle; the started event is removed from the pending count.
REQ-016 Latency: an accept in IDLE with pending=0 drives sensor_out=0 from the next rising edge; pending stays 0.
REQ-017 BREAK lasts exactly BREAK_CYC cycles, then -> GAP; sensor_out returns to 1 on that edge.
REQ-018 done_pulse=1 for exactly the first GAP cycle of every event.
REQ-019 GAP lasts exactly GAP_CYC cycles, then -> BREAK if pending>0 or an accept occurs that cycle, else -> IDLE.
REQ-020 A simultaneous accept and event start leaves pending unchanged.
REQ-021 pending never exceeds its maximum and never underflows.
REQ-022 evt_req=1 while evt_ready=0: request dropped; overflow set on the next edge; pending unchanged.
REQ-023 overflow clears only on reset.
REQ-024 Accepts are allowed in every state, including BREAK and GAP.

Reset
REQ-025 On reset: state IDLE, sensor_out=1, done_pulse=0, pending=0, overflow=0, busy=0, phase timer=0.
REQ-026 Reset asserted mid-BREAK: sensor_out=1 from the next edge; all pending events are discarded.
REQ-027 evt_req is ignored in any cycle with reset=1.

Configuration
REQ-028 With macro PHOTO_EMU_COUNT_EN defined, output evt_total (16-bit) is present.
REQ-029 evt_total increments on every done_pulse, wraps from 65535 to 0, and resets to 0.
REQ-030 Without PHOTO_EMU_COUNT_EN, the evt_total port and its counter are absent; all other behaviour is identical.

Structure
REQ-031 Shared package photo_pkg holds the state enum (IDLE, BREAK, GAP), default BREAK_CYC/GAP_CYC constants and the 8-bit timer width constant.
REQ-032 Sub-module photo_phase_timer: 8-bit loadable down-counter with load value input and an expiry flag; instantiated once.

Verification
REQ-033 Single event: reset, then evt_req=1 for 1 cycle -> sensor_out low for exactly 3 cycles from the next edge, done_pulse high 1 cycle, IDLE after 2 gap cycles.
REQ-034 Back-to-back: 3 accepts on consecutive cycles -> three 3-cycle low pulses separated by exactly 2 high cycles; pending sequence 0,1,2,1,0.
REQ-035 Overflow: PEND_W=2, 5 requests held during one BREAK -> pending saturates at 3, evt_ready=0, overflow=1 and stays 1 until reset.
REQ-036 Reset mid-BREAK with pending=2 -> next edge sensor_out=1, pending=0, busy=0, no done_pulse.
REQ-037 Loopback: sensor_out drives the existing photocell detector; N=10 accepted events -> exactly 10 detector output pulses.
REQ-038 With PHOTO_EMU_COUNT_EN defined and evt_total forced to 65535 -> after one event, evt_total=0.

Source files
------------

// File: rtl/photo_pkg.sv
// Shared types and constants for the photocell emulator.
//   photo_state_e : emulator phase (IDLE beam clear, BREAK beam broken, GAP recovery)
//   TMR_W         : width of the phase timer
//   DEF_*_CYC     : default break / gap durations in clock cycles
package photo_pkg;

    localparam int unsigned TMR_W         = 8;
    localparam int unsigned DEF_BREAK_CYC = 3;
    localparam int unsigned DEF_GAP_CYC   = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BREAK = 2'd1,
        GAP   = 2'd2
    } photo_state_e;

endpackage

// File: rtl/photo_phase_timer.sv
// Loadable down-counter that times the BREAK and GAP phases.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   load, load_val  : load the counter with load_val (takes priority over counting)
//   expired_c       : counter is at zero (combinational decode of the count register)
module photo_phase_timer
    import photo_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    output logic             expired_c
);

    logic [TMR_W-1:0] count;

    // Count down to zero and hold there until reloaded.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - TMR_W'(1);
        end
    end

    assign expired_c = (count == '0);

endmodule

// File: rtl/photocell_emulator.sv
// Photocell emulator: turns queued event requests into beam-break pulses on
// sensor_out (low for BREAK_CYC cycles, then high for at least GAP_CYC cycles).
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   evt_req     : request one beam-break event
//   evt_ready   : request can be accepted (pending counter not full), combinational
//   sensor_out  : emulated photocell line, 1 = clear, 0 = broken
//   done_pulse  : one-cycle pulse in the first GAP cycle of each event
//   pending     : accepted events not yet started
//   busy        : emulator in BREAK or GAP
//   overflow    : sticky, a request arrived while evt_ready was low
//   evt_total   : completed-event counter, present only with PHOTO_EMU_COUNT_EN defined
module photocell_emulator
    import photo_pkg::*;
#(
    parameter int unsigned BREAK_CYC = DEF_BREAK_CYC,
    parameter int unsigned GAP_CYC   = DEF_GAP_CYC,
    parameter int unsigned PEND_W    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              evt_req,
    output logic              evt_ready,
    output logic              sensor_out,
    output logic              done_pulse,
    output logic [PEND_W-1:0] pending,
    output logic              busy,
    output logic              overflow
`ifdef PHOTO_EMU_COUNT_EN
    ,
    output logic [15:0]       evt_total
`endif
);

    localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};
    localparam logic [TMR_W-1:0]  BREAK_LD  = TMR_W'(BREAK_CYC - 1);
    localparam logic [TMR_W-1:0]  GAP_LD    = TMR_W'(GAP_CYC - 1);

    photo_state_e      state;
    photo_state_e      state_nxt;
    logic [PEND_W-1:0] pending_nxt;
    logic              accept;
    logic              want_start;
    logic              start;
    logic              tmr_load;
    logic [TMR_W-1:0]  tmr_val;
    logic              tmr_expired;

    assign evt_ready  = (pending != PEND_MAX);
    assign accept     = evt_req & evt_ready;
    assign want_start = (pending != '0) | accept;

    photo_phase_timer u_timer (
        .clk       (clk),
        .reset     (reset),
        .load      (tmr_load),
        .load_val  (tmr_val),
        .expired_c (tmr_expired)
    );

    // Next-state, event start and timer load decisions.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        case (state)
            IDLE: begin
                if (want_start) begin
                    state_nxt = BREAK;
                    start     = 1'b1;
                    tmr_load  = 1'b1;
                    tmr_val   = BREAK_LD;
                end
            end
            BREAK: begin
                if (tmr_expired) begin
                    state_nxt = GAP;
                    tmr_load  = 1'b1;
                    tmr_val   = GAP_LD;
                end
            end
            GAP: begin
                if (tmr_expired) begin
                    if (want_start) begin
                        state_nxt = BREAK;
                        start     = 1'b1;
                        tmr_load  = 1'b1;
                        tmr_val   = BREAK_LD;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // An accept and a start in the same cycle cancel; start implies pending>0 or accept.
    always_comb begin
        pending_nxt = pending;
        case ({accept, start})
            2'b10:   pending_nxt = pending + PEND_W'(1);
            2'b01:   pending_nxt = pending - PEND_W'(1);
            default: pending_nxt = pending;
        endcase
    end

    // State and registered outputs; outputs track the next state so they align with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            sensor_out <= 1'b1;
            busy       <= 1'b0;
            done_pulse <= 1'b0;
            pending    <= '0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_nxt;
            sensor_out <= (state_nxt != BREAK);
            busy       <= (state_nxt != IDLE);
            done_pulse <= (state == BREAK) && tmr_expired;
            pending    <= pending_nxt;
            overflow   <= overflow | (evt_req & ~evt_ready);
        end
    end

`ifdef PHOTO_EMU_COUNT_EN
    // Completed-event counter, wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            evt_total <= '0;
        end else if (done_pulse) begin
            evt_total <= evt_total + 16'd1;
        end
    end
`endif

endmodule
